// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : shared widths and run-control reset values for the CPU core
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_IRQ_W = 16;

  // The first cycle out of reset is always an enabled cycle.
  localparam logic RST_CLK_EN = 1'b1;
  localparam logic RST_HALT   = 1'b0;
  localparam logic RST_SLEEP  = 1'b0;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/cpu_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_if : control-register/writeback inputs and run-state outputs
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface cpu_run_ctrl_if
  import cpu_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int IRQ_W = DEF_IRQ_W
);

  logic [CNT_W-1:0] clock_divider;
  logic             wb_halt;
  logic             wb_sleep;
  logic [IRQ_W-1:0] interrupts;
  logic             clk_en;
  logic             halt;
  logic             sleep;
  logic             halt_or_sleep;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output clock_divider, wb_halt, wb_sleep, interrupts,
    input  clk_en, halt, sleep, halt_or_sleep, cycle_count
  );

  modport slave (
    input  clock_divider, wb_halt, wb_sleep, interrupts,
    output clk_en, halt, sleep, halt_or_sleep, cycle_count
  );

endinterface : cpu_run_ctrl_if

`default_nettype wire

// File: rtl/run_cycle_counter.sv
// ---------------------------------------------------------------------------
// run_cycle_counter : free-running cycle counter, frozen once the core halts
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module run_cycle_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             halt,
  output logic      [CNT_W-1:0] cycle_count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Not gated by clk_en or sleep: this counts real clock cycles and wraps.
  always_comb begin
    count_d = count_q;
    if (!halt) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign cycle_count = count_q;

endmodule : run_cycle_counter

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl : clock-enable divider, halt/sleep latches and cycle counter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int IRQ_W = DEF_IRQ_W
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  cpu_run_ctrl_if.slave bus
);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;
  logic             clk_en_q;
  logic             clk_en_d;
  logic             halt_q;
  logic             halt_d;
  logic             sleep_q;
  logic             sleep_d;
  logic [IRQ_W-1:0] irq;
  logic [CNT_W-1:0] cycle_count;

  assign irq = bus.interrupts;

  // Unsigned >= so that lowering the divider below div_cnt restarts at once.
  always_comb begin
    div_cnt_d = div_cnt_q + CNT_W'(1);
    clk_en_d  = 1'b0;
    if (div_cnt_q >= bus.clock_divider) begin
      div_cnt_d = '0;
      clk_en_d  = 1'b1;
    end
  end

  // Halt and sleep only move on enabled edges; halt is sticky until reset.
  always_comb begin
    halt_d  = halt_q;
    sleep_d = sleep_q;
    if (clk_en_q) begin
      halt_d = halt_q | bus.wb_halt;
      if (sleep_q) begin
        sleep_d = (irq == '0);
      end else begin
        sleep_d = bus.wb_sleep;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      clk_en_q  <= RST_CLK_EN;
      halt_q    <= RST_HALT;
      sleep_q   <= RST_SLEEP;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_en_q  <= clk_en_d;
      halt_q    <= halt_d;
      sleep_q   <= sleep_d;
    end
  end

  run_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt_q),
    .cycle_count (cycle_count)
  );

  assign bus.clk_en        = clk_en_q;
  assign bus.halt          = halt_q;
  assign bus.sleep         = sleep_q;
  assign bus.halt_or_sleep = halt_q | sleep_q;
  assign bus.cycle_count   = cycle_count;

endmodule : cpu_run_ctrl

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl : vector-table bench for cpu_run_ctrl with a 4-bit wrap DUT
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_run_ctrl;
  import cpu_pkg::*;

  localparam int CNT_W = 32;
  localparam int IRQ_W = 16;
  localparam int SW    = 4;

  typedef struct {
    logic        rst;
    logic [31:0] div;
    logic        wh;
    logic        ws;
    logic [15:0] irq;
    logic        en;
    logic        h;
    logic        s;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic rst_s_n = 1'b0;

  vec_t vecs[64];
  int   nvec  = 0;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.CNT_W(CNT_W), .IRQ_W(IRQ_W)) bus ();
  cpu_run_ctrl_if #(.CNT_W(SW),    .IRQ_W(IRQ_W)) sbus ();

  cpu_run_ctrl #(.CNT_W(CNT_W), .IRQ_W(IRQ_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  cpu_run_ctrl #(.CNT_W(SW), .IRQ_W(IRQ_W)) dut_s (
    .clk   (clk),
    .rst_n (rst_s_n),
    .bus   (sbus.slave)
  );

  function automatic logic [63:0] pack(input logic en, input logic h, input logic s,
                                       input logic hos, input logic [31:0] cnt);
    return {en, h, s, hos, 28'd0, cnt};
  endfunction

  function automatic logic [63:0] act_main();
    return pack(bus.clk_en, bus.halt, bus.sleep, bus.halt_or_sleep, bus.cycle_count);
  endfunction

  function automatic logic [63:0] act_small();
    return pack(sbus.clk_en, sbus.halt, sbus.sleep, sbus.halt_or_sleep, {28'd0, sbus.cycle_count});
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {en,h,s,hos,cnt}=%h expected %h", tag, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [31:0] d, input logic wh, input logic ws,
                     input logic [15:0] irq, input logic en, input logic h, input logic s,
                     input logic [31:0] cnt);
    vecs[nvec] = '{rst: r, div: d, wh: wh, ws: ws, irq: irq, en: en, h: h, s: s, cnt: cnt};
    nvec++;
  endtask

  // Entered at a negedge; returns at a negedge with rst_n released.
  task automatic do_reset(input logic [31:0] div);
    rst_n             = 1'b0;
    bus.clock_divider = div;
    bus.wb_halt       = 1'b0;
    bus.wb_sleep      = 1'b0;
    bus.interrupts    = '0;
    #1;
    check("reset_async", act_main(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
    @(posedge clk);
    #1;
    check("reset_hold", act_main(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;

    //  rst  div  wh  ws  irq       en  h  s  cnt
    // divider 0: enabled every cycle, counter 1,2,3,4
    add(1, 0, 0, 0, 16'h0000, 1, 0, 0, 1);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 0, 2);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 0, 3);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 0, 4);
    // divider 2: 0,0,1,0,0 after the reset pulse, then drop to 0 with div_cnt=2
    add(1, 2, 0, 0, 16'h0000, 0, 0, 0, 1);
    add(0, 2, 0, 0, 16'h0000, 0, 0, 0, 2);
    add(0, 2, 0, 0, 16'h0000, 1, 0, 0, 3);
    add(0, 2, 0, 0, 16'h0000, 0, 0, 0, 4);
    add(0, 2, 0, 0, 16'h0000, 0, 0, 0, 5);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 0, 6);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 0, 7);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 0, 8);
    // divider 3: wb_halt on a disabled edge ignored, on an enabled edge sticks
    add(1, 3, 0, 0, 16'h0000, 0, 0, 0, 1);
    add(0, 3, 1, 0, 16'h0000, 0, 0, 0, 2);
    add(0, 3, 0, 0, 16'h0000, 0, 0, 0, 3);
    add(0, 3, 0, 0, 16'h0000, 1, 0, 0, 4);
    add(0, 3, 1, 0, 16'h0000, 0, 1, 0, 5);
    add(0, 3, 0, 0, 16'h0000, 0, 1, 0, 5);
    add(0, 3, 1, 0, 16'h0000, 0, 1, 0, 5);
    add(0, 3, 0, 0, 16'h0000, 1, 1, 0, 5);
    add(0, 3, 0, 0, 16'h0000, 0, 1, 0, 5);
    // divider 0: sleep with no interrupts, held 5 cycles, woken by irq bit 2
    add(1, 0, 0, 1, 16'h0000, 1, 0, 1, 1);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 1, 2);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 1, 3);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 1, 4);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 1, 5);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 1, 6);
    add(0, 0, 0, 0, 16'h0004, 1, 0, 0, 7);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 0, 8);
    // wb_sleep with an interrupt already pending: exactly one sleeping cycle
    add(0, 0, 0, 1, 16'h0001, 1, 0, 1, 9);
    add(0, 0, 0, 0, 16'h0001, 1, 0, 0, 10);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 0, 11);
    // divider 1: sleep entry and wake only happen on enabled edges
    add(1, 1, 0, 0, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 0, 1, 16'h0000, 1, 0, 0, 2);
    add(0, 1, 0, 1, 16'h0000, 0, 0, 1, 3);
    add(0, 1, 0, 0, 16'h8000, 1, 0, 1, 4);
    add(0, 1, 0, 0, 16'h8000, 0, 0, 0, 5);

    bus.clock_divider  = '0;
    bus.wb_halt        = 1'b0;
    bus.wb_sleep       = 1'b0;
    bus.interrupts     = '0;
    sbus.clock_divider = '0;
    sbus.wb_halt       = 1'b0;
    sbus.wb_sleep      = 1'b0;
    sbus.interrupts    = '0;

    @(negedge clk);
    for (int i = 0; i < nvec; i++) begin
      if (vecs[i].rst) begin
        do_reset(vecs[i].div);
      end
      bus.clock_divider = vecs[i].div;
      bus.wb_halt       = vecs[i].wh;
      bus.wb_sleep      = vecs[i].ws;
      bus.interrupts    = vecs[i].irq;
      sb.push_back('{tag: $sformatf("vec%0d", i),
                     val: pack(vecs[i].en, vecs[i].h, vecs[i].s,
                               vecs[i].h | vecs[i].s, vecs[i].cnt)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(e.tag, act_main(), e.val);
      @(negedge clk);
    end

    // 4-bit counter build: wrap F->0, then asynchronous reset mid-count
    sbus.clock_divider = 4'd2;
    rst_s_n = 1'b0;
    #1;
    check("small_reset", act_small(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    rst_s_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      sb.push_back('{tag: $sformatf("wrap_k%0d", k),
                     val: pack((k % 3) == 0, 1'b0, 1'b0, 1'b0, 32'(k % 16))});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(e.tag, act_small(), e.val);
      @(negedge clk);
    end
    rst_s_n = 1'b0;
    #1;
    check("small_async_reset", act_small(), pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_cpu_run_ctrl

`default_nettype wire
